falafel_req_parser_q: RTL and testbench

//  Front-end request parser: consumes the single-word valid/ready host request stream, decodes

---
 rtl/falafel_pkg.sv | 39 +++
 rtl/falafel_fifo_lvl.sv | 63 ++++++
 rtl/falafel_req_parser_q.sv | 205 ++++++++++++++++++++
 tb/tb_falafel_req_parser_q.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/falafel_pkg.sv
// Shared types for the falafel request path: header layouts, queue entries and opcodes.
package falafel_pkg;

   localparam int DATA_W        = 64;
   localparam int OPCODE_W      = 8;
   localparam int MSG_ID_SIZE   = 8;
   localparam int REG_ADDR_SIZE = 8;

   typedef enum logic [OPCODE_W-1:0] {
      REQ_ALLOC_MEM       = 8'h01,
      REQ_FREE_MEM        = 8'h02,
      REQ_ACCESS_REGISTER = 8'h03,
      REQ_READ_REGISTER   = 8'h04
   } opcode_e;

   typedef struct packed {
      logic [OPCODE_W-1:0]                     opcode;
      logic [MSG_ID_SIZE-1:0]                  id;
      logic [DATA_W-OPCODE_W-MSG_ID_SIZE-1:0]  rsvd;
   } base_header_t;

   typedef struct packed {
      logic [OPCODE_W-1:0]                                   opcode;
      logic [MSG_ID_SIZE-1:0]                                id;
      logic [REG_ADDR_SIZE-1:0]                              addr;
      logic [DATA_W-OPCODE_W-MSG_ID_SIZE-REG_ADDR_SIZE-1:0]  rsvd;
   } config_reg_header_t;

   typedef struct packed {
      logic [MSG_ID_SIZE-1:0] id;
      logic [DATA_W-1:0]      payload;
   } alloc_entry_t;

   typedef struct packed {
      logic [MSG_ID_SIZE-1:0]   id;
      logic [REG_ADDR_SIZE-1:0] addr;
   } cfg_rd_req_t;

endpackage

// File: rtl/falafel_fifo_lvl.sv
// Registered-pointer FIFO with occupancy output; pushes become visible one cycle later.
module falafel_fifo_lvl #(
   parameter int DATA_W      = 8,
   parameter int NUM_ENTRIES = 4
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             push_i,
   input  logic [DATA_W-1:0]                push_data_i,
   output logic                             full_o,
   output logic                             pop_val_o,
   input  logic                             pop_rdy_i,
   output logic [DATA_W-1:0]                pop_data_o,
   output logic [$clog2(NUM_ENTRIES):0]     level_o
);

   localparam int PTR_W = $clog2(NUM_ENTRIES);

   logic [DATA_W-1:0] mem_r [NUM_ENTRIES];
   logic [PTR_W:0]    wr_ptr_r;
   logic [PTR_W:0]    rd_ptr_r;
   logic              empty_s;
   logic              full_s;
   logic              push_s;
   logic              pop_s;

   // The extra MSB separates full (same index, different lap) from empty.
   assign empty_s = (wr_ptr_r == rd_ptr_r);
   assign full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                    (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
   assign push_s  = push_i && !full_s;
   assign pop_s   = !empty_s && pop_rdy_i;

   assign full_o     = full_s;
   assign pop_val_o  = !empty_s;
   assign pop_data_o = mem_r[rd_ptr_r[PTR_W-1:0]];
   assign level_o    = wr_ptr_r - rd_ptr_r;

   // Pointer update
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_r <= {(PTR_W+1){1'b0}};
         rd_ptr_r <= {(PTR_W+1){1'b0}};
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + {{PTR_W{1'b0}}, 1'b1};
         else        wr_ptr_r <= wr_ptr_r;
         if (pop_s)  rd_ptr_r <= rd_ptr_r + {{PTR_W{1'b0}}, 1'b1};
         else        rd_ptr_r <= rd_ptr_r;
      end
   end

   // Entry storage, cleared so the head reads zero out of reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_ENTRIES; i++) mem_r[i] <= {DATA_W{1'b0}};
      end else if (push_s) begin
         mem_r[wr_ptr_r[PTR_W-1:0]] <= push_data_i;
      end else begin
         mem_r <= mem_r;
      end
   end

endmodule

// File: rtl/falafel_req_parser_q.sv
// Host request parser: decodes headers, queues alloc/free payloads, issues config writes/reads
// and counts unknown opcodes.
module falafel_req_parser_q
   import falafel_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 8
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            req_val_i,
   output logic                            req_rdy_o,
   input  logic [DATA_W-1:0]               req_data_i,
   output logic                            alloc_req_val_o,
   input  logic                            alloc_req_rdy_i,
   output alloc_entry_t                    alloc_req_data_o,
   output logic                            free_req_val_o,
   input  logic                            free_req_rdy_i,
   output alloc_entry_t                    free_req_data_o,
   output logic [$clog2(FIFO_DEPTH):0]     alloc_level_o,
   output logic [$clog2(FIFO_DEPTH):0]     free_level_o,
   output logic                            cfg_wr_val_o,
   output logic [REG_ADDR_SIZE-1:0]        cfg_wr_addr_o,
   output logic [DATA_W-1:0]               cfg_wr_data_o,
   output logic                            cfg_rd_val_o,
   input  logic                            cfg_rd_rdy_i,
   output logic [REG_ADDR_SIZE-1:0]        cfg_rd_addr_o,
   output logic [MSG_ID_SIZE-1:0]          cfg_rd_id_o,
   output logic                            bad_opcode_o,
   output logic [CNT_W-1:0]                bad_opcode_cnt_o
);

   typedef enum logic [2:0] {
      ST_HDR   = 3'd0,
      ST_ALLOC = 3'd1,
      ST_FREE  = 3'd2,
      ST_CFGWR = 3'd3,
      ST_CFGRD = 3'd4
   } state_e;

   state_e                    state_r, state_nxt_s;
   cfg_rd_req_t               hdr_r;
   logic [OPCODE_W-1:0]       hdr_op_s;
   logic [MSG_ID_SIZE-1:0]    hdr_id_s;
   logic [REG_ADDR_SIZE-1:0]  hdr_addr_s;
   logic                      req_rdy_s;
   logic                      alloc_push_s, free_push_s;
   logic                      alloc_full_s, free_full_s;
   logic                      hdr_bad_s;
   logic                      cfg_wr_val_r;
   logic [REG_ADDR_SIZE-1:0]  cfg_wr_addr_r;
   logic [DATA_W-1:0]         cfg_wr_data_r;
   logic                      cfg_rd_val_r;
   logic                      bad_r;
   logic [CNT_W-1:0]          cnt_r;
   alloc_entry_t              push_entry_s;

   // Header fields, laid out as in config_reg_header_t
   assign hdr_op_s   = req_data_i[DATA_W-1 -: OPCODE_W];
   assign hdr_id_s   = req_data_i[DATA_W-OPCODE_W-1 -: MSG_ID_SIZE];
   assign hdr_addr_s = req_data_i[DATA_W-OPCODE_W-MSG_ID_SIZE-1 -: REG_ADDR_SIZE];

   assign push_entry_s = '{id: hdr_r.id, payload: req_data_i};

   // Next-state decode, ready and queue push; ready depends on state/occupancy only
   always_comb begin
      state_nxt_s  = state_r;
      req_rdy_s    = 1'b0;
      alloc_push_s = 1'b0;
      free_push_s  = 1'b0;
      hdr_bad_s    = 1'b0;
      case (state_r)
         ST_HDR: begin
            req_rdy_s = 1'b1;
            if (req_val_i) begin
               case (hdr_op_s)
                  REQ_ALLOC_MEM:       state_nxt_s = ST_ALLOC;
                  REQ_FREE_MEM:        state_nxt_s = ST_FREE;
                  REQ_ACCESS_REGISTER: state_nxt_s = ST_CFGWR;
                  REQ_READ_REGISTER:   state_nxt_s = ST_CFGRD;
                  default:             hdr_bad_s   = 1'b1;
               endcase
            end else begin
               state_nxt_s = ST_HDR;
            end
         end
         ST_ALLOC: begin
            req_rdy_s = !alloc_full_s;
            if (req_val_i && !alloc_full_s) begin
               alloc_push_s = 1'b1;
               state_nxt_s  = ST_HDR;
            end else begin
               state_nxt_s = ST_ALLOC;
            end
         end
         ST_FREE: begin
            req_rdy_s = !free_full_s;
            if (req_val_i && !free_full_s) begin
               free_push_s = 1'b1;
               state_nxt_s = ST_HDR;
            end else begin
               state_nxt_s = ST_FREE;
            end
         end
         ST_CFGWR: begin
            req_rdy_s = 1'b1;
            if (req_val_i) state_nxt_s = ST_HDR;
            else           state_nxt_s = ST_CFGWR;
         end
         ST_CFGRD: begin
            req_rdy_s = 1'b0;
            if (cfg_rd_rdy_i) state_nxt_s = ST_HDR;
            else              state_nxt_s = ST_CFGRD;
         end
         default: begin
            state_nxt_s = ST_HDR;
         end
      endcase
   end

   // State register and header id/addr latch
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= ST_HDR;
         hdr_r   <= '{id: {MSG_ID_SIZE{1'b0}}, addr: {REG_ADDR_SIZE{1'b0}}};
      end else begin
         state_r <= state_nxt_s;
         if (state_r == ST_HDR && req_val_i) hdr_r <= '{id: hdr_id_s, addr: hdr_addr_s};
         else                                hdr_r <= hdr_r;
      end
   end

   // Config write strobe/data and read-request valid
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cfg_wr_val_r  <= 1'b0;
         cfg_wr_addr_r <= {REG_ADDR_SIZE{1'b0}};
         cfg_wr_data_r <= {DATA_W{1'b0}};
         cfg_rd_val_r  <= 1'b0;
      end else begin
         cfg_wr_val_r <= (state_r == ST_CFGWR) && req_val_i;
         if (state_r == ST_CFGWR && req_val_i) begin
            cfg_wr_addr_r <= hdr_r.addr;
            cfg_wr_data_r <= req_data_i;
         end else begin
            cfg_wr_addr_r <= cfg_wr_addr_r;
            cfg_wr_data_r <= cfg_wr_data_r;
         end
         cfg_rd_val_r <= (state_nxt_s == ST_CFGRD);
      end
   end

   // Unknown-opcode pulse and saturating counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bad_r <= 1'b0;
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         bad_r <= hdr_bad_s;
         if (hdr_bad_s && cnt_r != {CNT_W{1'b1}}) cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         else                                    cnt_r <= cnt_r;
      end
   end

   falafel_fifo_lvl #(
      .DATA_W      ($bits(alloc_entry_t)),
      .NUM_ENTRIES (FIFO_DEPTH)
   ) u_alloc_q (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (alloc_push_s),
      .push_data_i (push_entry_s),
      .full_o      (alloc_full_s),
      .pop_val_o   (alloc_req_val_o),
      .pop_rdy_i   (alloc_req_rdy_i),
      .pop_data_o  (alloc_req_data_o),
      .level_o     (alloc_level_o)
   );

   falafel_fifo_lvl #(
      .DATA_W      ($bits(alloc_entry_t)),
      .NUM_ENTRIES (FIFO_DEPTH)
   ) u_free_q (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (free_push_s),
      .push_data_i (push_entry_s),
      .full_o      (free_full_s),
      .pop_val_o   (free_req_val_o),
      .pop_rdy_i   (free_req_rdy_i),
      .pop_data_o  (free_req_data_o),
      .level_o     (free_level_o)
   );

   assign req_rdy_o        = req_rdy_s;
   assign cfg_wr_val_o     = cfg_wr_val_r;
   assign cfg_wr_addr_o    = cfg_wr_addr_r;
   assign cfg_wr_data_o    = cfg_wr_data_r;
   assign cfg_rd_val_o     = cfg_rd_val_r;
   assign cfg_rd_addr_o    = hdr_r.addr;
   assign cfg_rd_id_o      = hdr_r.id;
   assign bad_opcode_o     = bad_r;
   assign bad_opcode_cnt_o = cnt_r;

endmodule

// File: tb/tb_falafel_req_parser_q.sv
// Randomised + directed bench for falafel_req_parser_q against a message-level queue model.
module tb_falafel_req_parser_q;
   import falafel_pkg::*;

   logic               clk_i = 1'b0;
   logic               rst_ni;
   logic               req_val_i;
   logic               req_rdy_o;
   logic [63:0]        req_data_i;
   logic               alloc_req_val_o, alloc_req_rdy_i;
   alloc_entry_t       alloc_req_data_o;
   logic               free_req_val_o, free_req_rdy_i;
   alloc_entry_t       free_req_data_o;
   logic [2:0]         alloc_level_o, free_level_o;
   logic               cfg_wr_val_o;
   logic [7:0]         cfg_wr_addr_o;
   logic [63:0]        cfg_wr_data_o;
   logic               cfg_rd_val_o, cfg_rd_rdy_i;
   logic [7:0]         cfg_rd_addr_o;
   logic [7:0]         cfg_rd_id_o;
   logic               bad_opcode_o;
   logic [7:0]         bad_opcode_cnt_o;

   falafel_req_parser_q #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_val_i(req_val_i), .req_rdy_o(req_rdy_o), .req_data_i(req_data_i),
      .alloc_req_val_o(alloc_req_val_o), .alloc_req_rdy_i(alloc_req_rdy_i),
      .alloc_req_data_o(alloc_req_data_o),
      .free_req_val_o(free_req_val_o), .free_req_rdy_i(free_req_rdy_i),
      .free_req_data_o(free_req_data_o),
      .alloc_level_o(alloc_level_o), .free_level_o(free_level_o),
      .cfg_wr_val_o(cfg_wr_val_o), .cfg_wr_addr_o(cfg_wr_addr_o), .cfg_wr_data_o(cfg_wr_data_o),
      .cfg_rd_val_o(cfg_rd_val_o), .cfg_rd_rdy_i(cfg_rd_rdy_i),
      .cfg_rd_addr_o(cfg_rd_addr_o), .cfg_rd_id_o(cfg_rd_id_o),
      .bad_opcode_o(bad_opcode_o), .bad_opcode_cnt_o(bad_opcode_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] hdr(input logic [7:0] op, input logic [7:0] id,
                                       input logic [7:0] addr);
      return {op, id, addr, 40'h0};
   endfunction

   // ---------------- behavioural model: what is pending, what is queued ----------------
   int          pend;        // 0 header expected, 1 alloc, 2 free, 3 cfg write, 4 cfg read
   logic [7:0]  m_id, m_addr;
   logic [71:0] aq[$];
   logic [71:0] fq[$];
   bit          m_wr;
   logic [7:0]  m_wr_addr;
   logic [63:0] m_wr_data;
   bit          m_bad;
   int          m_cnt;
   bit          chk_en = 1'b0;

   function automatic bit m_rdy();
      case (pend)
         0, 3:    return 1'b1;
         1:       return aq.size() < 4;
         2:       return fq.size() < 4;
         default: return 1'b0;
      endcase
   endfunction

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend = 0; m_id = 8'h0; m_addr = 8'h0; aq.delete(); fq.delete();
         m_wr = 1'b0; m_wr_addr = 8'h0; m_wr_data = 64'h0; m_bad = 1'b0; m_cnt = 0;
      end else begin
         bit acc, pop_a, pop_f, push_a, push_f;
         logic [7:0] op;
         acc    = req_val_i && m_rdy();
         pop_a  = (aq.size() > 0) && alloc_req_rdy_i;
         pop_f  = (fq.size() > 0) && free_req_rdy_i;
         push_a = acc && pend == 1;
         push_f = acc && pend == 2;
         m_wr   = 1'b0;
         m_bad  = 1'b0;
         if (pop_a) void'(aq.pop_front());
         if (pop_f) void'(fq.pop_front());
         if (push_a) aq.push_back({m_id, req_data_i});
         if (push_f) fq.push_back({m_id, req_data_i});
         case (pend)
            0: if (acc) begin
               op = req_data_i[63:56];
               if (op >= 8'd1 && op <= 8'd4) begin
                  pend   = int'(op);
                  m_id   = req_data_i[55:48];
                  m_addr = req_data_i[47:40];
               end else begin
                  m_bad = 1'b1;
                  if (m_cnt < 255) m_cnt++;
               end
            end
            1, 2: if (acc) pend = 0;
            3: if (acc) begin
               m_wr = 1'b1; m_wr_addr = m_addr; m_wr_data = req_data_i; pend = 0;
            end
            default: if (cfg_rd_rdy_i) pend = 0;
         endcase
      end
   end

   // compare every cycle against the model, away from the active edge
   always @(negedge clk_i) begin
      if (rst_ni && chk_en) begin
         chk("req_rdy", req_rdy_o, m_rdy());
         chk("alloc_val", alloc_req_val_o, aq.size() != 0);
         chk("alloc_lvl", alloc_level_o, aq.size());
         if (aq.size() != 0) chk("alloc_data", alloc_req_data_o, aq[0]);
         chk("free_val", free_req_val_o, fq.size() != 0);
         chk("free_lvl", free_level_o, fq.size());
         if (fq.size() != 0) chk("free_data", free_req_data_o, fq[0]);
         chk("cfg_wr_val", cfg_wr_val_o, m_wr);
         if (m_wr) begin
            chk("cfg_wr_addr", cfg_wr_addr_o, m_wr_addr);
            chk("cfg_wr_data", cfg_wr_data_o, m_wr_data);
         end
         chk("cfg_rd_val", cfg_rd_val_o, pend == 4);
         if (pend == 4) begin
            chk("cfg_rd_addr", cfg_rd_addr_o, m_addr);
            chk("cfg_rd_id", cfg_rd_id_o, m_id);
         end
         chk("bad_pulse", bad_opcode_o, m_bad);
         chk("bad_cnt", bad_opcode_cnt_o, m_cnt);
      end
   end

   int bad_seen = 0;
   always @(negedge clk_i) if (rst_ni && bad_opcode_o) bad_seen++;

   // ---------------- stimulus helpers ----------------
   task automatic send_word(input logic [63:0] w);
      bit done;
      done = 1'b0;
      req_val_i  = 1'b1;
      req_data_i = w;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk_i);
         if (req_rdy_o) done = 1'b1;
         @(posedge clk_i);
      end
      #1 req_val_i = 1'b0;
      if (!done) begin
         n_tests++; n_fail++;
         $display("FAIL send_word: word %0h not accepted within 200 cycles", w);
      end
   endtask

   task automatic tick();
      @(posedge clk_i); #1;
   endtask

   logic [63:0] words[$];
   logic [7:0]  got_ids[$];

   initial begin
      rst_ni = 1'b0; req_val_i = 1'b0; req_data_i = 64'h0;
      alloc_req_rdy_i = 1'b0; free_req_rdy_i = 1'b0; cfg_rd_rdy_i = 1'b0;
      #22;
      chk("rst_alloc_val", alloc_req_val_o, 1'b0);
      chk("rst_free_val", free_req_val_o, 1'b0);
      chk("rst_levels", {alloc_level_o, free_level_o}, 6'd0);
      chk("rst_cfg", {cfg_wr_val_o, cfg_rd_val_o, cfg_rd_addr_o, cfg_rd_id_o}, 18'd0);
      chk("rst_bad", {bad_opcode_o, bad_opcode_cnt_o}, 9'd0);
      #1 rst_ni = 1'b1;
      chk_en = 1'b1;
      tick();

      // 1. single alloc message
      send_word(hdr(8'h01, 8'd5, 8'd0));
      send_word(64'h40);
      chk("t1_val", alloc_req_val_o, 1'b1);
      chk("t1_data", alloc_req_data_o, {8'd5, 64'h40});
      chk("t1_lvl", alloc_level_o, 3'd1);
      alloc_req_rdy_i = 1'b1; tick(); alloc_req_rdy_i = 1'b0;
      chk("t1_drained", alloc_level_o, 3'd0);

      // 2. backpressure: fill, stall fifth payload, pop one, drain in order
      for (int i = 0; i < 4; i++) begin
         send_word(hdr(8'h01, 8'(11 + i), 8'd0));
         send_word(64'(100 + i));
      end
      chk("t2_full", alloc_level_o, 3'd4);
      send_word(hdr(8'h01, 8'd15, 8'd0));
      req_val_i = 1'b1; req_data_i = 64'd104;
      repeat (3) begin
         @(negedge clk_i);
         chk("t2_stall_rdy", req_rdy_o, 1'b0);
      end
      tick(); alloc_req_rdy_i = 1'b1; tick(); alloc_req_rdy_i = 1'b0;
      send_word(64'd104);
      chk("t2_refill", alloc_level_o, 3'd4);
      alloc_req_rdy_i = 1'b1;
      repeat (8) begin
         @(negedge clk_i);
         if (alloc_req_val_o) got_ids.push_back(alloc_req_data_o.id);
      end
      tick(); alloc_req_rdy_i = 1'b0;
      chk("t2_cnt", got_ids.size(), 4);
      for (int k = 0; k < 4 && k < got_ids.size(); k++) chk("t2_order", got_ids[k], 8'(12 + k));

      // 3. config write
      send_word(hdr(8'h03, 8'd0, 8'd3));
      send_word(64'hDEAD);
      chk("t3_wr", {cfg_wr_val_o, cfg_wr_addr_o, cfg_wr_data_o}, {1'b1, 8'd3, 64'hDEAD});
      tick();
      chk("t3_pulse_end", cfg_wr_val_o, 1'b0);

      // 4. config read with backpressure
      send_word(hdr(8'h04, 8'd9, 8'd7));
      repeat (3) begin
         chk("t4_hold", {cfg_rd_val_o, req_rdy_o, cfg_rd_addr_o, cfg_rd_id_o},
             {1'b1, 1'b0, 8'd7, 8'd9});
         tick();
      end
      cfg_rd_rdy_i = 1'b1; tick(); cfg_rd_rdy_i = 1'b0;
      chk("t4_done", {cfg_rd_val_o, req_rdy_o}, 2'b01);

      // random message stream
      repeat (150) begin
         int k;
         k = $urandom_range(0, 4);
         case (k)
            0, 1: begin
               words.push_back(hdr(8'(k + 1), 8'($urandom), 8'($urandom)));
               words.push_back({$urandom, $urandom});
            end
            2: begin
               words.push_back(hdr(8'h03, 8'($urandom), 8'($urandom)));
               words.push_back({$urandom, $urandom});
            end
            3: words.push_back(hdr(8'h04, 8'($urandom), 8'($urandom)));
            default: words.push_back(hdr(($urandom_range(0, 1) != 0) ? 8'h00 :
                                         8'($urandom_range(5, 255)), 8'($urandom), 8'h0));
         endcase
      end
      begin
         int idx, cyc;
         bit rdy_seen;
         idx = 0; cyc = 0;
         while (idx < words.size() && cyc < 20000) begin
            @(negedge clk_i); rdy_seen = req_rdy_o;
            @(posedge clk_i);
            if (req_val_i && rdy_seen) idx++;
            #1;
            if (idx < words.size()) begin
               req_val_i  = ($urandom_range(0, 3) != 0);
               req_data_i = words[idx];
            end else begin
               req_val_i = 1'b0;
            end
            alloc_req_rdy_i = ($urandom_range(0, 1) != 0);
            free_req_rdy_i  = ($urandom_range(0, 1) != 0);
            cfg_rd_rdy_i    = ($urandom_range(0, 1) != 0);
            cyc++;
         end
         chk("rand_all_sent", idx, words.size());
      end
      req_val_i = 1'b0; alloc_req_rdy_i = 1'b1; free_req_rdy_i = 1'b1; cfg_rd_rdy_i = 1'b1;
      repeat (10) tick();
      alloc_req_rdy_i = 1'b0; free_req_rdy_i = 1'b0; cfg_rd_rdy_i = 1'b0;

      // 5. 300 unknown headers back to back, then a normal alloc
      bad_seen = 0;
      for (int i = 0; i < 300; i++) send_word(hdr(8'hEE, 8'(i), 8'h0));
      tick(); tick();
      chk("t5_pulses", bad_seen, 300);
      chk("t5_cnt", bad_opcode_cnt_o, 8'd255);
      send_word(hdr(8'h01, 8'h21, 8'h0));
      send_word(64'hABC);
      chk("t5_alloc", {alloc_req_val_o, alloc_req_data_o}, {1'b1, 8'h21, 64'hABC});
      alloc_req_rdy_i = 1'b1; tick(); alloc_req_rdy_i = 1'b0;

      // 6. reset while mid-message with two entries queued
      for (int i = 0; i < 2; i++) begin
         send_word(hdr(8'h01, 8'(40 + i), 8'h0));
         send_word(64'(i + 1));
      end
      send_word(hdr(8'h01, 8'h31, 8'h0));
      #3 rst_ni = 1'b0;
      #1;
      chk("t6_vals", {alloc_req_val_o, free_req_val_o, cfg_wr_val_o, cfg_rd_val_o, bad_opcode_o},
          5'd0);
      chk("t6_levels", {alloc_level_o, free_level_o}, 6'd0);
      chk("t6_regs", {bad_opcode_cnt_o, cfg_rd_addr_o, cfg_rd_id_o}, 24'd0);
      #2 rst_ni = 1'b1;
      tick();
      send_word(hdr(8'h02, 8'h33, 8'h0));
      send_word(64'h77);
      chk("t6_free", {free_req_val_o, free_req_data_o}, {1'b1, 8'h33, 64'h77});
      chk("t6_alloc_lvl", alloc_level_o, 3'd0);
      free_req_rdy_i = 1'b1; tick(); free_req_rdy_i = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
